// File: rtl/tow_pkg.sv
// Shared types and encodings for the tug-of-war game sequencer.
package tow_pkg;

    typedef enum logic [1:0] {START, PLAY, HOLD, OVER} tow_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_R    = 2'b01;
    localparam logic [1:0] WIN_L    = 2'b10;

endpackage

// File: rtl/tow_key_pulse.sv
// One player's key: rising-edge detect feeding a pending-move latch that the tick clears.
module tow_key_pulse (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic enable,
    input  logic clear,
    output logic pend
);

    logic key_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    assign rise = key & ~key_q;

    // A rise landing in the clear cycle survives into the next tick window.
    always_comb begin
        pend_d = pend_q | rise;
        if (!enable) begin
            pend_d = 1'b0;
        end else if (clear) begin
            pend_d = rise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            key_q  <= key;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/tow_game_ctrl.sv
// Tug-of-war sequencer: tick divider, move requests, win detection, scoring and round control.
module tow_game_ctrl
    import tow_pkg::*;
#(
    parameter int unsigned N_LIGHTS   = 9,
    parameter int unsigned TICK_DIV   = 4,
    parameter int unsigned HOLD_TICKS = 8,
    parameter int unsigned SCORE_MAX  = 7,
    localparam int unsigned SCORE_W   = $clog2(SCORE_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_l,
    input  logic                key_r,
    input  logic [N_LIGHTS-1:0] light_vec,
    output logic                ce,
    output logic                move_l,
    output logic                move_r,
    output logic                round_rst,
    output logic [SCORE_W-1:0]  score_l,
    output logic [SCORE_W-1:0]  score_r,
    output logic [1:0]          winner,
    output logic                match_over
);

    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);
    localparam logic [SCORE_W-1:0] SCORE_TOP = SCORE_W'(SCORE_MAX);

    tow_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [1:0]         winner_q, winner_d;
    logic               ce_q, ce_d;
    logic               move_l_q, move_l_d;
    logic               move_r_q, move_r_d;
    logic               round_rst_q, round_rst_d;

    logic tick;
    logic pend_l, pend_r;
    logic pend_en, pend_clr;
    logic win_l, win_r;

    assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    tow_key_pulse u_key_l (
        .clk    (clk),
        .reset  (reset),
        .key    (key_l),
        .enable (pend_en),
        .clear  (pend_clr),
        .pend   (pend_l)
    );

    tow_key_pulse u_key_r (
        .clk    (clk),
        .reset  (reset),
        .key    (key_r),
        .enable (pend_en),
        .clear  (pend_clr),
        .pend   (pend_r)
    );

    // Judged on the moves about to be issued: the light is pushed off on the coming ce.
    assign win_l = light_vec[N_LIGHTS-1] & pend_l & ~pend_r;
    assign win_r = light_vec[0] & pend_r & ~pend_l;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        winner_d    = winner_q;
        ce_d        = 1'b0;
        move_l_d    = 1'b0;
        move_r_d    = 1'b0;
        round_rst_d = 1'b0;
        pend_en     = 1'b0;
        pend_clr    = 1'b0;
        unique case (state_q)
            START: begin
                round_rst_d = 1'b1;
                state_d     = PLAY;
            end
            PLAY: begin
                pend_en = 1'b1;
                if (tick) begin
                    pend_clr = 1'b1;
                    ce_d     = 1'b1;
                    move_l_d = pend_l;
                    move_r_d = pend_r;
                    if (win_l) begin
                        if (score_l_q != SCORE_TOP) score_l_d = score_l_q + 1'b1;
                        winner_d = WIN_L;
                        hold_d   = HOLD_W'(HOLD_TICKS);
                        state_d  = HOLD;
                    end else if (win_r) begin
                        if (score_r_q != SCORE_TOP) score_r_d = score_r_q + 1'b1;
                        winner_d = WIN_R;
                        hold_d   = HOLD_W'(HOLD_TICKS);
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    hold_d = (hold_q != '0) ? hold_q - 1'b1 : '0;
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d = (score_l_q == SCORE_TOP || score_r_q == SCORE_TOP) ? OVER : START;
                    end
                end
            end
            OVER: begin
            end
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= START;
            cnt_q       <= '0;
            hold_q      <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            winner_q    <= WIN_NONE;
            ce_q        <= 1'b0;
            move_l_q    <= 1'b0;
            move_r_q    <= 1'b0;
            round_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_q    <= winner_d;
            ce_q        <= ce_d;
            move_l_q    <= move_l_d;
            move_r_q    <= move_r_d;
            round_rst_q <= round_rst_d;
        end
    end

    assign ce         = ce_q;
    assign move_l     = move_l_q;
    assign move_r     = move_r_q;
    assign round_rst  = round_rst_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign winner     = winner_q;
    assign match_over = (state_q == OVER);

endmodule

// File: tb/tb_tow_game_ctrl.sv
// Directed bench for tow_game_ctrl: per-cycle vector table plus round/match sequences.
module tb_tow_game_ctrl;

    localparam int N = 9;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_l;
    logic       key_r;
    logic [N-1:0] light_vec;
    logic       ce;
    logic       move_l;
    logic       move_r;
    logic       round_rst;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic [1:0] winner;
    logic       match_over;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic kl;
        logic kr;
        logic ce;
        logic ml;
        logic mr;
        logic rr;
    } vec_t;

    vec_t vecs [28];

    tow_game_ctrl #(
        .N_LIGHTS   (9),
        .TICK_DIV   (4),
        .HOLD_TICKS (8),
        .SCORE_MAX  (7)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_l      (key_l),
        .key_r      (key_r),
        .light_vec  (light_vec),
        .ce         (ce),
        .move_l     (move_l),
        .move_r     (move_r),
        .round_rst  (round_rst),
        .score_l    (score_l),
        .score_r    (score_r),
        .winner     (winner),
        .match_over (match_over)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Steps until ce is seen; n is the number of edges taken.
    task automatic wait_ce(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ce && n < 20);
        if (!ce) check("wait_ce_timeout", 32'(ce), 32'd1);
    endtask

    // Steps until round_rst is seen, counting ce pulses along the way.
    task automatic wait_rr(output int n, output int ces);
        n   = 0;
        ces = 0;
        do begin
            step();
            n++;
            if (ce) ces++;
        end while (!round_rst && n < 60);
        if (!round_rst) check("wait_rr_timeout", 32'(round_rst), 32'd1);
    endtask

    // Called in the cycle a round_rst is observed; plays one winning push.
    task automatic play_round(input bit left, input string tag);
        int n;
        light_vec = left ? 9'b1_0000_0000 : 9'b0_0000_0001;
        if (left) key_l = 1'b1;
        else      key_r = 1'b1;
        step();
        key_l = 1'b0;
        key_r = 1'b0;
        wait_ce(n);
        check({tag, "_move"}, {30'd0, move_l, move_r}, left ? 32'd2 : 32'd1);
        light_vec = 9'b0_0001_0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int ces;

        reset     = 1'b1;
        key_l     = 1'b0;
        key_r     = 1'b0;
        light_vec = '0;

        for (int i = 0; i < 28; i++) vecs[i] = '0;
        vecs[0].rr = 1'b1;
        for (int i = 3; i < 28; i += 4) vecs[i].ce = 1'b1;
        for (int i = 2; i <= 7; i++) vecs[i].kl = 1'b1;
        vecs[9].kl  = 1'b1;
        vecs[9].kr  = 1'b1;
        vecs[19].kr = 1'b1;
        vecs[3].ml  = 1'b1;
        vecs[11].ml = 1'b1;
        vecs[11].mr = 1'b1;
        vecs[23].mr = 1'b1;

        step();
        step();
        check("reset_outputs",
              {19'd0, ce, move_l, move_r, round_rst, score_l, score_r, winner, match_over},
              32'd0);
        reset = 1'b0;

        // Held key, simultaneous keys, and a rise landing in the tick cycle.
        for (int i = 0; i < 28; i++) begin
            key_l = vecs[i].kl;
            key_r = vecs[i].kr;
            step();
            checks++;
            if ({ce, move_l, move_r, round_rst} !== {vecs[i].ce, vecs[i].ml, vecs[i].mr, vecs[i].rr}
                || score_l !== 3'd0 || score_r !== 3'd0 || winner !== 2'b00) begin
                errors++;
                $display("FAIL vec[%0d]: got ce/ml/mr/rr=%b%b%b%b sl=%0d sr=%0d w=%b, expected %b%b%b%b 0 0 00",
                         i, ce, move_l, move_r, round_rst, score_l, score_r, winner,
                         vecs[i].ce, vecs[i].ml, vecs[i].mr, vecs[i].rr);
            end
        end

        // Left push off the leftmost cell.
        key_l = 1'b0;
        key_r = 1'b0;
        light_vec = 9'b1_0000_0000;
        key_l = 1'b1;
        step();
        key_l = 1'b0;
        wait_ce(n);
        check("win_l_ce_latency", 32'(n), 32'd3);
        check("win_l_move", {30'd0, move_l, move_r}, 32'd2);
        check("win_l_score", 32'(score_l), 32'd1);
        check("win_l_winner", 32'(winner), 32'd2);
        light_vec = 9'b0_0001_0000;
        wait_rr(n, ces);
        check("hold_len", 32'(n), 32'd33);
        check("hold_no_ce", 32'(ces), 32'd0);
        check("winner_kept_after_start", 32'(winner), 32'd2);
        wait_ce(n);
        check("play_resumes", 32'(n), 32'd3);

        // Right wins the match.
        do_reset();
        step();
        check("match_first_rr", 32'(round_rst), 32'd1);
        for (int r = 1; r <= 7; r++) begin
            play_round(1'b0, "right_round");
            check("right_score", 32'(score_r), 32'(r));
            check("right_winner", 32'(winner), 32'd1);
            if (r < 7) begin
                wait_rr(n, ces);
                check("right_hold_no_ce", 32'(ces), 32'd0);
            end
        end
        ces = 0;
        n   = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ce) ces++;
            if (round_rst) n++;
        end
        check("match_over", 32'(match_over), 32'd1);
        check("over_no_rr", 32'(n), 32'd0);
        for (int i = 0; i < 40; i++) begin
            key_l     = (i % 3) == 0;
            key_r     = (i % 5) == 1;
            light_vec = (i % 2) ? 9'b1_0000_0001 : 9'b0;
            step();
            if (ce || move_l || move_r || round_rst) ces++;
        end
        check("over_frozen_outputs", 32'(ces), 32'd0);
        check("over_frozen_scores", {24'd0, score_l, score_r, winner}, {24'd0, 3'd0, 3'd7, 2'b01});
        check("over_sticky", 32'(match_over), 32'd1);
        key_l = 1'b0;
        key_r = 1'b0;

        // Reset while holding after a third left win.
        do_reset();
        step();
        for (int r = 1; r <= 3; r++) begin
            play_round(1'b1, "left_round");
            if (r < 3) wait_rr(n, ces);
        end
        step();
        step();
        check("pre_reset_score_l", 32'(score_l), 32'd3);
        reset = 1'b1;
        step();
        check("reset_in_hold",
              {19'd0, ce, move_l, move_r, round_rst, score_l, score_r, winner, match_over},
              32'd0);
        reset = 1'b0;
        step();
        check("rr_after_reset", 32'(round_rst), 32'd1);
        step();
        check("rr_one_cycle", 32'(round_rst), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
